// File: rtl/mio_bus_ctrl_pkg.sv
// mio_bus_pkg
// Shared definitions for the memory/IO bus controller: the address map
// constants, the value returned by unmapped reads when bus-error reporting
// is built in, the controller FSM state encoding and the decoded
// access-target encoding.
// No ports (package).
package mio_bus_pkg;

  // Address map. Everything is word addressed; addr[1:0] never matters.
  localparam logic [3:0]  RAM_REGION = 4'h0;
  localparam logic [31:0] GPIO_ADDR  = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR    = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR   = 32'hF000_0004;

  // Read data for unmapped reads when MIO_BUS_ERR_EN is defined.
  localparam logic [31:0] DEAD_BEEF  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_GPIO,
    TGT_SW,
    TGT_CNT,
    TGT_NONE
  } target_t;

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// mio_bus_ctrl_if
// CPU-side request/ready handshake between the single-cycle core and the
// memory/IO bus controller.
//   cpu_req    core -> ctrl  access request, level, held until mio_ready
//   cpu_we     core -> ctrl  1 = write, 0 = read
//   cpu_addr   core -> ctrl  byte address
//   cpu_wdata  core -> ctrl  write data
//   cpu_rdata  ctrl -> core  read data
//   mio_ready  ctrl -> core  one-cycle completion pulse
// Modports: master (core side), slave (controller side).
interface mio_bus_ctrl_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        mio_ready;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, mio_ready
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, mio_ready
  );

endinterface

// File: rtl/mio_bus_ctrl_addr_decode.sv
// mio_addr_decode
// Purely combinational address-to-target decoder.
//   addr  in  32  byte address from the core
//   tgt   out     decoded target (RAM, GPIO, switches, counter, none)
// The whole 0x0xxx_xxxx region is RAM; the upper RAM address bits alias.
module mio_addr_decode
  import mio_bus_pkg::*;
(
  input  logic [31:0] addr,
  output target_t     tgt
);

  logic [31:0] word_addr;

  // Peripheral matches compare the word address, so the two byte-offset
  // bits are masked off before comparing.
  always_comb begin
    word_addr = addr & ~32'h3;
    tgt       = TGT_NONE;
    if (addr[31:28] == RAM_REGION) begin
      tgt = TGT_RAM;
    end else if (word_addr == GPIO_ADDR) begin
      tgt = TGT_GPIO;
    end else if (word_addr == SW_ADDR) begin
      tgt = TGT_SW;
    end else if (word_addr == CNT_ADDR) begin
      tgt = TGT_CNT;
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl
// Memory/IO bus controller sitting between the single-cycle core and the
// data RAM / on-chip peripherals. One transaction at a time: IO accesses
// complete in the cycle after the request, RAM accesses go through an
// ACCESS cycle and RAM_WAIT wait cycles.
// Ports:
//   clk       in          system clock, rising edge
//   rst       in          asynchronous, active-low reset
//   bus       slave       CPU handshake (mio_bus_ctrl_if)
//   ram_addr  out RAM_AW  RAM word address (latched request address)
//   ram_din   out 32      RAM write data (latched request data)
//   ram_we    out 1       RAM write enable, only during ACCESS
//   ram_dout  in  32      RAM read data, valid one cycle after address
//   sw_in     in  32      switch inputs
//   gpio_out  out 32      GPIO/LED register
//   bus_err   out 1       sticky unmapped-access flag
// Build option: define MIO_BUS_ERR_EN to return DEAD_BEEF on unmapped reads
// and report unmapped accesses on bus_err; otherwise bus_err is tied low.
// RAM_WAIT must lie in 1..15 (4-bit wait counter).
module mio_bus_ctrl
  import mio_bus_pkg::*;
#(
  parameter int          RAM_AW   = 10,
  parameter int          RAM_WAIT = 1,
  parameter logic [31:0] GPIO_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  mio_bus_ctrl_if.slave     bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [31:0]       sw_in,
  output logic [31:0]       gpio_out,
  output logic              bus_err
);

  state_t            state_q;
  state_t            state_d;
  target_t           tgt;
  logic [RAM_AW-1:0] lat_idx;
  logic              lat_we;
  logic [31:0]       lat_wdata;
  logic [3:0]        wait_cnt;
  logic [31:0]       rdata_q;
  logic [31:0]       gpio_q;
  logic [31:0]       cnt_q;
  logic [31:0]       io_rdata;
  logic              start;
  logic              io_start;
  logic              last_wait;
  logic              ram_we_c;
  logic              ready_c;

  mio_addr_decode u_decode (
    .addr (bus.cpu_addr),
    .tgt  (tgt)
  );

  always_comb begin
    start     = (state_q == ST_IDLE) && bus.cpu_req;
    io_start  = start && (tgt != TGT_RAM);
    last_wait = (state_q == ST_WAIT) && (wait_cnt == 4'd1);
  end

  // The counter read returns the value including the sampling edge, so a
  // value W written at cycle T reads back as W + (T' - T) at cycle T'.
  always_comb begin
    io_rdata = 32'h0;
    case (tgt)
      TGT_GPIO: io_rdata = gpio_q;
      TGT_SW:   io_rdata = sw_in;
      TGT_CNT:  io_rdata = cnt_q + 32'd1;
`ifdef MIO_BUS_ERR_EN
      TGT_NONE: io_rdata = DEAD_BEEF;
`else
      TGT_NONE: io_rdata = 32'h0;
`endif
      default:  io_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ram_we and mio_ready decode straight from the state register, so a
  // reset drops them immediately without waiting for a clock.
  always_comb begin
    state_d  = state_q;
    ram_we_c = 1'b0;
    ready_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          state_d = (tgt == TGT_RAM) ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        ram_we_c = lat_we;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_idx   <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= 32'h0;
    end else if (start) begin
      lat_idx   <= bus.cpu_addr[RAM_AW+1:2];
      lat_we    <= bus.cpu_we;
      lat_wdata <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 4'd0;
    end else if (state_q == ST_ACCESS) begin
      wait_cnt <= 4'(RAM_WAIT);
    end else if (state_q == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Read data is only ever written by a read capture; writes leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'h0;
    end else if (io_start && !bus.cpu_we) begin
      rdata_q <= io_rdata;
    end else if (last_wait && !lat_we) begin
      rdata_q <= ram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_q <= GPIO_RST;
    end else if (io_start && bus.cpu_we && (tgt == TGT_GPIO)) begin
      gpio_q <= bus.cpu_wdata;
    end
  end

  // A write on the same edge takes priority over the free-running increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 32'h0;
    end else if (io_start && bus.cpu_we && (tgt == TGT_CNT)) begin
      cnt_q <= bus.cpu_wdata;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

`ifdef MIO_BUS_ERR_EN
  logic bus_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_q <= 1'b0;
    end else if (io_start && (tgt == TGT_NONE)) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign bus.cpu_rdata = rdata_q;
  assign bus.mio_ready = ready_c;
  assign ram_addr      = lat_idx;
  assign ram_din       = lat_wdata;
  assign ram_we        = ram_we_c;
  assign gpio_out      = gpio_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl
// Scoreboard bench for mio_bus_ctrl with RAM_WAIT = 2 and a non-zero GPIO
// reset value. Stimulus pushes the expected read data and completion cycle
// for each transaction; an independent monitor pops and compares whenever
// mio_ready is seen. A small behavioural RAM sits on the RAM port.
module tb_mio_bus_ctrl;

  localparam int          RAM_AW   = 10;
  localparam int          RAM_WAIT = 2;
  localparam logic [31:0] GPIO_RST = 32'h0000_0F0F;
  localparam int          LAT_IO   = 1;
  localparam int          LAT_RAM  = 2 + RAM_WAIT;
  localparam int          TIMEOUT  = 40;

`ifdef MIO_BUS_ERR_EN
  localparam logic [31:0] UNMAPPED_RD = 32'hDEAD_BEEF;
  localparam logic        BUS_ERR_EXP = 1'b1;
`else
  localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;
  localparam logic        BUS_ERR_EXP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] rdata;
    int          ready_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;
  logic [31:0]       sw_in;
  logic [31:0]       gpio_out;
  logic              bus_err;

  logic [31:0] mem [0:(1<<RAM_AW)-1];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          issue_cyc = 0;
  int          we_count = 0;
  int          we_cyc = 0;
  logic [31:0] we_addr = 32'h0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] cnt_w = 32'h0;
  int          cnt_cyc = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;

  mio_bus_ctrl_if bus ();

  mio_bus_ctrl #(
    .RAM_AW   (RAM_AW),
    .RAM_WAIT (RAM_WAIT),
    .GPIO_RST (GPIO_RST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .sw_in    (sw_in),
    .gpio_out (gpio_out),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model: one-cycle read latency, write-first not needed.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor: every mio_ready pulse must match a queued transaction.
  always @(negedge clk) begin
    if (bus.mio_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected mio_ready at cycle %0d: got 1 expected 0", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput({mon_e.name, " rdata"}, bus.cpu_rdata, mon_e.rdata);
        checkOutput({mon_e.name, " ready cycle"}, 32'(cyc), 32'(mon_e.ready_cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      we_count++;
      we_cyc  = cyc;
      we_addr = 32'(ram_addr);
    end
  end

  // Issues one transaction in a fresh IDLE cycle and holds req until ready.
  // cnt_rel derives the expected read from the last counter write.
  task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd_exp,
                               input int lat, input bit cnt_rel);
    exp_t e;
    int   waited;
    @(posedge clk);
    #1;
    issue_cyc = cyc;
    if (cnt_rel) rd_exp = cnt_w + 32'(issue_cyc - cnt_cyc);
    if (!we) last_rd = rd_exp;
    if (we && addr == 32'hF000_0004) begin
      cnt_w   = wdata;
      cnt_cyc = issue_cyc;
    end
    e.name      = name;
    e.rdata     = last_rd;
    e.ready_cyc = issue_cyc + lat;
    sb_q.push_back(e);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.mio_ready !== 1'b1 && waited < TIMEOUT);
    if (bus.mio_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no mio_ready expected ready within %0d cycles", name, TIMEOUT);
      void'(sb_q.pop_back());
    end
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'h0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    sw_in         = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset gpio_out", gpio_out, GPIO_RST);
    checkOutput("reset cpu_rdata", bus.cpu_rdata, 32'h0);
    checkOutput("reset mio_ready", 32'(bus.mio_ready), 32'h0);
    checkOutput("reset ram_we", 32'(ram_we), 32'h0);
    checkOutput("reset bus_err", 32'(bus_err), 32'h0);
    checkOutput("reset ram_addr", 32'(ram_addr), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // IO write to GPIO
    applyStimulus("gpio write", 1'b1, 32'hE000_0000, 32'h0000_A5A5, 32'h0, LAT_IO, 1'b0);
    checkOutput("gpio after write", gpio_out, 32'h0000_A5A5);
    checkOutput("ram_we count after io", 32'(we_count), 32'd0);

    // RAM write then read back, including aliasing and byte-offset bits
    applyStimulus("ram write", 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, LAT_RAM, 1'b0);
    checkOutput("ram_we count", 32'(we_count), 32'd1);
    checkOutput("ram_we cycle", 32'(we_cyc), 32'(issue_cyc + 1));
    checkOutput("ram_we addr", we_addr, 32'd4);
    applyStimulus("ram read", 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, LAT_RAM, 1'b0);
    applyStimulus("ram alias read", 1'b0, 32'h0000_1013, 32'h0, 32'h1234_5678, LAT_RAM, 1'b0);
    checkOutput("ram_we count after reads", 32'(we_count), 32'd1);
    applyStimulus("gpio read", 1'b0, 32'hE000_0000, 32'h0, 32'h0000_A5A5, LAT_IO, 1'b0);

    // Counter: write near the top, read back across the wrap
    applyStimulus("cnt write", 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 32'h0, LAT_IO, 1'b0);
    applyStimulus("cnt read wrap", 1'b0, 32'hF000_0004, 32'h0, 32'h0, LAT_IO, 1'b1);
    repeat (3) @(posedge clk);
    applyStimulus("cnt read later", 1'b0, 32'hF000_0004, 32'h0, 32'h0, LAT_IO, 1'b1);

    // Switches are read-only
    sw_in = 32'h0000_00C3;
    applyStimulus("sw read", 1'b0, 32'hF000_0000, 32'h0, 32'h0000_00C3, LAT_IO, 1'b0);
    applyStimulus("sw write", 1'b1, 32'hF000_0000, 32'h0000_FFFF, 32'h0, LAT_IO, 1'b0);
    checkOutput("gpio after sw write", gpio_out, 32'h0000_A5A5);
    sw_in = 32'h0000_005A;
    applyStimulus("sw read 2", 1'b0, 32'hF000_0000, 32'h0, 32'h0000_005A, LAT_IO, 1'b0);

    // Reset during ACCESS of a RAM write: ram_we must drop at once
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h0000_0020;
    bus.cpu_wdata = 32'hDEAD_0001;
    @(posedge clk);
    #1;
    checkOutput("abort ram_we before reset", 32'(ram_we), 32'd1);
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    checkOutput("abort ram_we after reset", 32'(ram_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last_rd = 32'h0;

    // Reset during WAIT of a RAM read: no ready, read data cleared
    applyStimulus("sw read 3", 1'b0, 32'hF000_0000, 32'h0, 32'h0000_005A, LAT_IO, 1'b0);
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0000_0010;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    checkOutput("abort cpu_rdata", bus.cpu_rdata, 32'h0);
    checkOutput("abort gpio reset", gpio_out, GPIO_RST);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_rd = 32'h0;
    applyStimulus("ram read after abort", 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, LAT_RAM, 1'b0);
    applyStimulus("ram aborted write", 1'b0, 32'h0000_0020, 32'h0, 32'h0, LAT_RAM, 1'b0);

    // Unmapped accesses
    applyStimulus("unmapped read", 1'b0, 32'h8000_0000, 32'h0, UNMAPPED_RD, LAT_IO, 1'b0);
    checkOutput("bus_err after unmapped", 32'(bus_err), 32'(BUS_ERR_EXP));
    applyStimulus("unmapped write", 1'b1, 32'h8000_0000, 32'h0000_1111, 32'h0, LAT_IO, 1'b0);
    applyStimulus("gpio read after unmapped", 1'b0, 32'hE000_0000, 32'h0, GPIO_RST, LAT_IO, 1'b0);
    checkOutput("bus_err sticky", 32'(bus_err), 32'(BUS_ERR_EXP));

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
Memory/IO bus controller directly downstream of the single-cycle CPU core. It consumes the core's Addr_out/Data_out/MemRW/CPU_MIO and returns Data_in and MIO_ready. It decodes addresses into synchronous data RAM or on-chip peripherals (GPIO out, switches, cycle counter), inserts RAM wait states and runs a one-transaction-at-a-time request/ready handshake.

Parameters:
RAM_AW, 10, RAM word-address width (2^RAM_AW words)
RAM_WAIT, 1, extra cycles between RAM address issue and read-data capture; legal range is 1..15
GPIO_RST, 32'h0000_0000, reset value of the GPIO output register

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  access request (core CPU_MIO); level, held until mio_ready
cpu_we  in  1  1=write, 0=read (core MemRW)
cpu_addr  in  32  byte address (core Addr_out)
cpu_wdata  in  32  write data (core Data_out)
cpu_rdata  out  32  read data (to core Data_in)
mio_ready  out  1  one-cycle completion pulse (to core MIO_ready)
ram_addr  out  RAM_AW  RAM word address
ram_din  out  32  RAM write data
ram_we  out  1  RAM write enable
ram_dout  in  32  RAM read data, valid one cycle after address
sw_in  in  32  switch inputs
gpio_out  out  32  GPIO/LED register
bus_err  out  1  sticky unmapped-access flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE; cpu_rdata=0, mio_ready=0, ram_we=0, gpio_out=GPIO_RST, counter=0, bus_err=0; latched addr/wdata/we=0.
- Address map (word accesses; addr[1:0] ignored):
  - addr[31:28]=4'h0: RAM, word index addr[RAM_AW+1:2]. Higher bits alias (wrap).
  - 32'hE000_0000: GPIO. Read/write.
  - 32'hF000_0000: switches. Read-only; writes ignored.
  - 32'hF000_0004: counter. Read/write.
  - Anything else: unmapped.
- Counter: 32-bit, increments every cycle and wraps 0xFFFF_FFFF->0. A write on the same edge wins, so the counter loads cpu_wdata and does not increment that cycle.
- FSM states: IDLE, ACCESS, WAIT, DONE.
  - IDLE, cpu_req=1 at cycle T: latch addr/we/wdata at end of T.
    - RAM target: go to ACCESS.
    - Non-RAM target: perform the IO write or capture the IO read into cpu_rdata at end of T, then go to DONE.
  - ACCESS (one cycle): ram_addr/ram_din driven from the latched values; ram_we=latched we. Go to WAIT with wait count=RAM_WAIT.
  - WAIT: decrement the count. At the last WAIT cycle, capture ram_dout into cpu_rdata on reads, then go to DONE.
  - DONE: mio_ready=1 for exactly this cycle, cpu_rdata stable, then go to IDLE unconditionally.
- Latency: IO access ready at T+1. RAM access ready at T+2+RAM_WAIT.
- At least one IDLE cycle separates transactions. A req still high in the IDLE after DONE starts a new transaction.
- ram_we is high only in ACCESS and is never asserted for non-RAM or read accesses. ram_addr/ram_din hold the latched values outside ACCESS.
- cpu_rdata holds its last captured value until the next capture. It is unchanged by writes.
- cpu_req dropping mid-transaction does not abort; the transaction completes normally.
- Reset mid-transaction: immediate return to IDLE, no mio_ready, ram_we deasserts asynchronously, and a pending IO write is not performed.
- The cpu_req value sampled in DONE is ignored.

Optional Feature:
- Macro MIO_BUS_ERR_EN.
- Defined: an unmapped access completes at T+1 like IO. Reads return 32'hDEAD_BEEF. bus_err sets at the end of T and stays set until reset.
- Undefined: unmapped reads return 0, writes are dropped, bus_err is tied to 0.

Decomposition:
- Package mio_bus_pkg holds:
  - address constants: RAM region nibble, GPIO, SW and CNT addresses
  - the DEAD_BEEF constant
  - the FSM state enum (2-bit)
  - a target enum: TGT_RAM, TGT_GPIO, TGT_SW, TGT_CNT, TGT_NONE
- Natural sub-module: mio_addr_decode, a combinational address-to-target decoder, instanced once in IDLE decode.

Test Plan:
- Reset, then IO write: req, we=1, addr=E000_0000, wdata=0000_A5A5 at T. mio_ready pulses at T+1 only; gpio_out=0000_A5A5 from T+1. ram_we never high.
- RAM write/read, RAM_WAIT=2: write addr=0000_0010, data=1234_5678. ram_we high only at T+1 with ram_addr=4. A later read returns 1234_5678 with mio_ready at T+4.
- Counter: write 0xFFFF_FFFE at T, read at next IDLE T'. Value = 0xFFFF_FFFE+(T'-T), showing wrap past 0xFFFF_FFFF. Write beats increment on the write edge.
- Switches: sw_in=0000_00C3, read F000_0000 returns 0000_00C3 at T+1. Write to F000_0000 changes nothing.
- Reset abort: assert rst during WAIT of a RAM read. No mio_ready; cpu_rdata=0. A new read after release returns correct data.
- Unmapped read of 8000_0000: with MIO_BUS_ERR_EN, DEAD_BEEF and bus_err=1 (sticky). Without it, 0 and bus_err=0.
